uart_rx_sampler: RTL and testbench

UART_RX_SAMPLER -- requirements
Module: uart_rx_sampler

---
 rtl/uart_defs.sv | 27 ++
 rtl/uart_sync.sv | 32 +++
 rtl/uart_rx_sampler.sv | 154 +++++++++++++++
 tb/tb_uart_rx_sampler.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_defs.sv
// rtl/uart_defs.sv - shared states, rates and sample points for the UART receive sampler
package uart_defs;

  typedef enum logic [1:0] {
    SMP_IDLE  = 2'd0,
    SMP_START = 2'd1,
    SMP_DATA  = 2'd2,
    SMP_STOP  = 2'd3
  } SampState_t;

  localparam int OS_RATE    = 16;
  localparam int OSC_W      = $clog2(OS_RATE);
  localparam int FRAME_BITS = 11;

  // Three samples around the bit centre feed the majority vote.
  localparam logic [OSC_W-1:0] SMP_PT_A = OSC_W'(7);
  localparam logic [OSC_W-1:0] SMP_PT_B = OSC_W'(8);
  localparam logic [OSC_W-1:0] SMP_PT_C = OSC_W'(9);

  // Index of the last bit handled in SMP_DATA (8 data bits + parity, counted from 0).
  localparam logic [3:0] LAST_DATA_IDX = 4'(FRAME_BITS - 3);

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_sync.sv
// rtl/uart_sync.sv - multi-flop synchroniser for an asynchronous single-bit input
// Ports:
//   clk  - destination clock
//   rst  - synchronous active-high reset, loads RST_VAL into every stage
//   d    - asynchronous input
//   q    - synchronised output
module uart_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  // Fewer than two stages gives no metastability protection, so clamp.
  localparam int N = (STAGES < 2) ? 2 : STAGES;

  logic [N-1:0] ff;

  always_ff @(posedge clk) begin
    if (rst) begin
      ff <= {N{RST_VAL}};
    end else begin
      ff <= {ff[N-2:0], d};
    end
  end

  assign q = ff[N-1];

endmodule

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - 16x oversampling UART bit sampler with majority vote
// Ports:
//   clk         - system clock
//   rst         - synchronous active-high reset
//   rx_i        - asynchronous UART line, idle high
//   enable_i    - permits detection of a new start bit
//   baud_div_i  - clk cycles per oversample tick (0 and 1 both mean every clk)
//   rx_o        - majority-voted bit value, held between strobes
//   tck_o       - one-clk strobe per sampled bit (start, 8 data, parity, stop)
//   busy_o      - high while a frame is in progress
//   glitch_o    - one-clk pulse when a start bit is rejected
//   frame_err_o - one-clk pulse with the stop-bit strobe when the stop bit is 0
module uart_rx_sampler #(
  parameter int SYNC_STAGES = 2,
  parameter int DIV_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_i,
  input  logic             enable_i,
  input  logic [DIV_W-1:0] baud_div_i,
  output logic             rx_o,
  output logic             tck_o,
  output logic             busy_o,
  output logic             glitch_o,
  output logic             frame_err_o
);

  import uart_defs::*;

  logic rxs;

  uart_sync #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(1'b1)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (rx_i),
    .q  (rxs)
  );

  // Free-running divider. The compare is against the live divisor, so a new
  // value is picked up at the next wrap; a shrink below the current count
  // wraps on the following clk.
  logic [DIV_W-1:0] div_cnt;
  logic             os_tick;

  assign os_tick = (baud_div_i <= DIV_W'(1)) ||
                   (div_cnt >= (baud_div_i - DIV_W'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (os_tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  SampState_t       state, state_n;
  logic [OSC_W-1:0] osc, osc_n;
  logic [3:0]       bit_cnt, bit_n;
  logic             s_a, s_a_n;
  logic             s_b, s_b_n;
  logic             rx_n, tck_n, glitch_n, ferr_n;
  logic             vote;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= SMP_IDLE;
      osc         <= '0;
      bit_cnt     <= '0;
      s_a         <= 1'b1;
      s_b         <= 1'b1;
      rx_o        <= 1'b1;
      tck_o       <= 1'b0;
      glitch_o    <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      state       <= state_n;
      osc         <= osc_n;
      bit_cnt     <= bit_n;
      s_a         <= s_a_n;
      s_b         <= s_b_n;
      rx_o        <= rx_n;
      tck_o       <= tck_n;
      glitch_o    <= glitch_n;
      frame_err_o <= ferr_n;
    end
  end

  always_comb begin
    state_n  = state;
    osc_n    = osc;
    bit_n    = bit_cnt;
    s_a_n    = s_a;
    s_b_n    = s_b;
    rx_n     = rx_o;
    tck_n    = 1'b0;
    glitch_n = 1'b0;
    ferr_n   = 1'b0;
    // Third sample is the live synchronised value at the last sample point.
    vote     = maj3(s_a, s_b, rxs);

    if (os_tick) begin
      if (state == SMP_IDLE) begin
        osc_n = '0;
        if (enable_i && !rxs) begin
          state_n = SMP_START;
          bit_n   = '0;
        end
      end else begin
        osc_n = osc + OSC_W'(1);
        if (osc == SMP_PT_A) s_a_n = rxs;
        if (osc == SMP_PT_B) s_b_n = rxs;
        if (osc == SMP_PT_C) begin
          case (state)
            SMP_START: begin
              if (vote) begin
                glitch_n = 1'b1;
                state_n  = SMP_IDLE;
              end else begin
                rx_n    = 1'b0;
                tck_n   = 1'b1;
                state_n = SMP_DATA;
              end
            end
            SMP_DATA: begin
              rx_n  = vote;
              tck_n = 1'b1;
              if (bit_cnt == LAST_DATA_IDX) begin
                state_n = SMP_STOP;
              end else begin
                bit_n = bit_cnt + 4'd1;
              end
            end
            SMP_STOP: begin
              rx_n    = vote;
              tck_n   = 1'b1;
              ferr_n  = !vote;
              state_n = SMP_IDLE;
            end
            default: state_n = SMP_IDLE;
          endcase
        end
      end
    end
  end

  assign busy_o = (state != SMP_IDLE);

endmodule

// File: tb/tb_uart_rx_sampler.sv
// tb/tb_uart_rx_sampler.sv - self-checking bench for uart_rx_sampler
module tb_uart_rx_sampler;

  localparam int DIV_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             rx_i = 1'b1;
  logic             enable_i = 1'b1;
  logic [DIV_W-1:0] baud_div_i = 16'd4;
  logic             rx_o, tck_o, busy_o, glitch_o, frame_err_o;

  int compared = 0;
  int mismatched = 0;

  uart_rx_sampler #(.SYNC_STAGES(2), .DIV_W(DIV_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_i       (rx_i),
    .enable_i   (enable_i),
    .baud_div_i (baud_div_i),
    .rx_o       (rx_o),
    .tck_o      (tck_o),
    .busy_o     (busy_o),
    .glitch_o   (glitch_o),
    .frame_err_o(frame_err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Observation of every strobe: value, clk index and frame_err at that strobe.
  logic rxq[$];
  int   tq[$];
  logic fq[$];
  int   ferr_cnt = 0, glitch_cnt = 0, wide_cnt = 0;
  bit   busy_seen = 1'b0;
  logic p_tck = 1'b0, p_gl = 1'b0, p_fe = 1'b0;

  always @(negedge clk) begin
    if (tck_o) begin
      rxq.push_back(rx_o);
      tq.push_back(cyc);
      fq.push_back(frame_err_o);
    end
    if (frame_err_o) ferr_cnt++;
    if (glitch_o) glitch_cnt++;
    if ((tck_o && p_tck) || (glitch_o && p_gl) || (frame_err_o && p_fe)) wide_cnt++;
    if (busy_o) busy_seen = 1'b1;
    p_tck = tck_o;
    p_gl  = glitch_o;
    p_fe  = frame_err_o;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int tk(input int d);
    return (d <= 1) ? 1 : d;
  endfunction

  // Line-level frame: bit 0 is the start bit, bit 10 the stop bit.
  function automatic logic [10:0] mk_frame(input logic [7:0] data, input logic par, input logic stop);
    return {stop, par, data, 1'b0};
  endfunction

  task automatic clear_obs();
    rxq.delete();
    tq.delete();
    fq.delete();
    ferr_cnt   = 0;
    glitch_cnt = 0;
    wide_cnt   = 0;
    busy_seen  = 1'b0;
  endtask

  task automatic send_frame(input logic [10:0] bits, input int d);
    for (int i = 0; i < 11; i++) begin
      rx_i = bits[i];
      repeat (16 * tk(d)) @(negedge clk);
    end
    rx_i = 1'b1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_o === 1'b1 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(busy_o), 32'd0);
  endtask

  task automatic wait_tcks(input int cnt, input string tag);
    int n = 0;
    while (rxq.size() < cnt && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(rxq.size() >= cnt), 32'd1);
  endtask

  task automatic check_frame(input logic [10:0] bits, input int d, input int exp_glitch, input string tag);
    logic [10:0] got = '0;
    logic [10:0] fv = '0;
    int bad = 0;
    for (int i = 0; i < rxq.size() && i < 11; i++) begin
      got[i] = rxq[i];
      fv[i]  = fq[i];
    end
    for (int i = 1; i < tq.size(); i++)
      if (tq[i] - tq[i-1] != 16 * tk(d)) bad++;
    chk({tag, "_n_tck"}, 32'(rxq.size()), 32'd11);
    chk({tag, "_rx_seq"}, 32'(got), 32'(bits));
    chk({tag, "_tck_gap"}, 32'(bad), 32'd0);
    chk({tag, "_ferr_at_stop"}, 32'(fv), 32'({!bits[10], 10'b0}));
    chk({tag, "_ferr_total"}, 32'(ferr_cnt), 32'(!bits[10]));
    chk({tag, "_glitch"}, 32'(glitch_cnt), 32'(exp_glitch));
    chk({tag, "_pulse_width"}, 32'(wide_cnt), 32'd0);
  endtask

  task automatic run_frame(input logic [10:0] bits, input int d, input string tag);
    baud_div_i = 16'(d);
    clear_obs();
    send_frame(bits, d);
    wait_idle();
    repeat (8 * tk(d)) @(negedge clk);
    // A 0 stop bit leaves the line low after the FSM is idle again: that
    // tail is seen as a start and then rejected once the line rises.
    check_frame(bits, d, bits[10] ? 0 : 1, tag);
  endtask

  initial begin
    logic [10:0] fr;
    logic [7:0]  data;
    logic        stop;
    int          d;
    int          n;

    // Reset values
    repeat (4) @(negedge clk);
    chk("rst_rx_o", 32'(rx_o), 32'd1);
    chk("rst_tck_o", 32'(tck_o), 32'd0);
    chk("rst_busy_o", 32'(busy_o), 32'd0);
    chk("rst_glitch_o", 32'(glitch_o), 32'd0);
    chk("rst_frame_err_o", 32'(frame_err_o), 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Directed 0x5A frame, parity 0, stop 1, divisor 4
    run_frame(mk_frame(8'h5A, 1'b0, 1'b1), 4, "f5a");
    chk("f5a_seq_literal", 32'(mk_frame(8'h5A, 1'b0, 1'b1)), 32'h4B4);

    // Short low pulse: rejected start
    d = $urandom_range(2, 4);
    baud_div_i = 16'(d);
    clear_obs();
    rx_i = 1'b0;
    repeat (3 * d) @(negedge clk);
    rx_i = 1'b1;
    repeat (24 * d) @(negedge clk);
    chk("glitch_count", 32'(glitch_cnt), 32'd1);
    chk("glitch_no_tck", 32'(rxq.size()), 32'd0);
    chk("glitch_busy_low", 32'(busy_o), 32'd0);

    // Stop bit 0
    data = 8'($urandom);
    run_frame(mk_frame(data, ^data, 1'b0), 3, "ferr");

    // Reset after the 4th strobe; upper data bits and trailer held high so
    // the rest of the line carries no further start edge.
    baud_div_i = 16'd3;
    clear_obs();
    data = 8'hFC | 8'($urandom_range(0, 3));
    fork
      send_frame(mk_frame(data, 1'b1, 1'b1), 3);
      begin
        wait_tcks(4, "rst_wait_tck4");
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_busy", 32'(busy_o), 32'd0);
        rst = 1'b0;
      end
    join
    wait_idle();
    chk("rst_mid_tck_count", 32'(rxq.size()), 32'd4);
    chk("rst_mid_glitch", 32'(glitch_cnt), 32'd0);
    run_frame(mk_frame(8'hFF, 1'b0, 1'b1), 3, "after_rst");

    // Enable dropped after the 2nd strobe: frame completes, next is ignored
    d = $urandom_range(2, 5);
    baud_div_i = 16'(d);
    clear_obs();
    data = 8'($urandom);
    fr = mk_frame(data, ^data, 1'b1);
    fork
      send_frame(fr, d);
      begin
        wait_tcks(2, "en_wait_tck2");
        enable_i = 1'b0;
      end
    join
    wait_idle();
    repeat (8 * d) @(negedge clk);
    check_frame(fr, d, 0, "en_drop");
    clear_obs();
    send_frame(mk_frame(8'h00, 1'b0, 1'b1), d);
    repeat (8 * d) @(negedge clk);
    chk("en_off_tck", 32'(rxq.size()), 32'd0);
    chk("en_off_busy_seen", 32'(busy_seen), 32'd0);
    enable_i = 1'b1;
    repeat (4 * d) @(negedge clk);

    // Divisor 0: one-clk low spike at the centre sample of a 1 data bit
    baud_div_i = 16'd0;
    clear_obs();
    data = 8'($urandom) | 8'h01;
    fr = mk_frame(data, ^data, 1'b1);
    fork
      send_frame(fr, 0);
      begin
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!tck_o && n < 5000);
        chk("spike_wait_tck", 32'(tck_o), 32'd1);
        repeat (12) @(negedge clk);
        rx_i = 1'b0;
        @(negedge clk);
        rx_i = 1'b1;
      end
    join
    wait_idle();
    repeat (8) @(negedge clk);
    check_frame(fr, 0, 0, "spike");

    // Random frames against the line-level model
    for (int k = 0; k < 5; k++) begin
      d    = $urandom_range(0, 5);
      data = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      run_frame(mk_frame(data, ^data, stop), d, $sformatf("rnd%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
